// File: rtl/mem_stage.sv
// mem_stage: latches execute bundles, runs data-memory ld/str over req/ack with timeout,
// and emits one registered writeback bundle per instruction.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_result,
  input  logic [3:0]  ex_rd_num,
  input  logic [31:0] ex_rd_val,
  input  logic [31:0] ex_md,
  input  logic [31:0] ex_cpsr,
  input  logic        ex_taken,
  input  logic        ex_is_alu_op,
  input  logic        ex_is_cmp_op,
  input  logic        ex_is_jmp_op,
  input  logic        ex_is_ld_op,
  input  logic        ex_is_str_op,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic        wb_reg_we,
  output logic [3:0]  wb_rd_num,
  output logic [31:0] wb_rd_val,
  output logic        wb_cpsr_we,
  output logic [31:0] wb_cpsr,
  output logic        wb_pc_we,
  output logic [31:0] wb_pc,
  output logic        mem_err
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  typedef enum logic {IDLE, ACCESS} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0] rd_q, rd_d;
  logic we_q, we_d, err_q, err_d;
  logic wb_valid_q, wb_valid_d, wb_reg_we_q, wb_reg_we_d, wb_cpsr_we_q, wb_cpsr_we_d, wb_pc_we_q, wb_pc_we_d;
  logic [3:0] wb_rd_num_q, wb_rd_num_d;
  logic [31:0] wb_rd_val_q, wb_rd_val_d, wb_cpsr_q, wb_cpsr_d, wb_pc_q, wb_pc_d;
  logic is_mem, is_alu, is_cmp, is_jmp, accept, done, abort;
  // Class priority ld > str > alu > cmp > jmp; no flag set means NOP.
  assign is_mem = ex_is_ld_op || ex_is_str_op;
  assign is_alu = !is_mem && ex_is_alu_op;
  assign is_cmp = !is_mem && !ex_is_alu_op && ex_is_cmp_op;
  assign is_jmp = !is_mem && !ex_is_alu_op && !ex_is_cmp_op && ex_is_jmp_op;
  assign accept = ex_valid && ex_ready;
  assign done   = mem_req && mem_ack;
  assign abort  = mem_req && !mem_ack && cnt_q == LAST;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == IDLE) ? ((accept && is_mem) ? ACCESS : IDLE)
                                : ((done || abort) ? IDLE : ACCESS);
  end
  always_comb begin
    ex_ready = (state_q == IDLE) && !rst;
    mem_req  = (state_q == ACCESS);
  end
  always_comb begin
    cnt_d        = mem_req ? cnt_q + 1'b1 : '0;
    addr_d       = accept ? ex_result : addr_q;
    wdata_d      = accept ? ex_rd_val : wdata_q;
    we_d         = accept ? !ex_is_ld_op : we_q;
    rd_d         = accept ? ex_rd_num : rd_q;
    err_d        = err_q || abort;
    wb_valid_d   = (accept && !is_mem) || done || abort;
    wb_reg_we_d  = (accept && is_alu) || (done && !we_q);
    wb_cpsr_we_d = accept && is_cmp;
    wb_pc_we_d   = accept && is_jmp && ex_taken;
    wb_rd_num_d  = wb_valid_d ? (mem_req ? rd_q : ex_rd_num) : wb_rd_num_q;
    wb_rd_val_d  = (accept && is_alu) ? ex_result : (done && !we_q) ? mem_rdata : wb_rd_val_q;
    wb_cpsr_d    = (accept && is_cmp) ? ex_cpsr : wb_cpsr_q;
    wb_pc_d      = (accept && is_jmp) ? ex_md : wb_pc_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      rd_q         <= '0;
      err_q        <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_reg_we_q  <= 1'b0;
      wb_cpsr_we_q <= 1'b0;
      wb_pc_we_q   <= 1'b0;
      wb_rd_num_q  <= '0;
      wb_rd_val_q  <= '0;
      wb_cpsr_q    <= '0;
      wb_pc_q      <= '0;
    end else begin
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      rd_q         <= rd_d;
      err_q        <= err_d;
      wb_valid_q   <= wb_valid_d;
      wb_reg_we_q  <= wb_reg_we_d;
      wb_cpsr_we_q <= wb_cpsr_we_d;
      wb_pc_we_q   <= wb_pc_we_d;
      wb_rd_num_q  <= wb_rd_num_d;
      wb_rd_val_q  <= wb_rd_val_d;
      wb_cpsr_q    <= wb_cpsr_d;
      wb_pc_q      <= wb_pc_d;
    end
  end
  // Address, direction and store data stay at zero through reset because the captures do.
  assign mem_we     = we_q && mem_req;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_err    = err_q;
  assign wb_valid   = wb_valid_q;
  assign wb_reg_we  = wb_reg_we_q;
  assign wb_cpsr_we = wb_cpsr_we_q;
  assign wb_pc_we   = wb_pc_we_q;
  assign wb_rd_num  = wb_rd_num_q;
  assign wb_rd_val  = wb_rd_val_q;
  assign wb_cpsr    = wb_cpsr_q;
  assign wb_pc      = wb_pc_q;
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipeline, directly downstream of `execute`. It latches execute's outputs and runs data-memory loads and stores over a req/ack handshake, stalling execute while an access is pending. It then presents one registered writeback bundle per instruction: register write, CPSR write and PC write. Non-memory instructions pass through with one cycle of latency. Memory instructions hold the stage until `mem_ack` arrives or the access times out.

## Interface
- `TIMEOUT`, default 16: maximum cycles spent in ACCESS before the access is aborted (≥2).
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `ex_valid` input 1: execute bundle valid this cycle.
- `ex_ready` output 1: stage can accept a bundle; equals (state==IDLE) && !rst.
- `ex_result` input 32: ALU result; also the memory word address for ld/str.
- `ex_rd_num` input 4: destination register number.
- `ex_rd_val` input 32: store data for str.
- `ex_md` input 32: sign-extended jump target.
- `ex_cpsr` input 32: CPSR value produced by cmp.
- `ex_taken` input 1: branch condition met.
- `ex_is_alu_op`, `ex_is_cmp_op`, `ex_is_jmp_op`, `ex_is_ld_op`, `ex_is_str_op` input 1 each: op class.
- `mem_req` output 1: memory request, held until ack or abort.
- `mem_we` output 1: 1 for store, 0 for load.
- `mem_addr` output 32: address.
- `mem_wdata` output 32: store data.
- `mem_rdata` input 32: load data, valid with `mem_ack`.
- `mem_ack` input 1: access complete; a single-cycle pulse.
- `wb_valid` output 1: writeback bundle valid; one-cycle pulse per instruction.
- `wb_reg_we` output 1: write `wb_rd_val` to `wb_rd_num`.
- `wb_rd_num` output 4, `wb_rd_val` output 32: register writeback.
- `wb_cpsr_we` output 1, `wb_cpsr` output 32: CPSR writeback.
- `wb_pc_we` output 1, `wb_pc` output 32: PC redirect.
- `mem_err` output 1: sticky timeout flag, cleared only by reset.

## Operation
- **Accept:** a bundle is accepted when `ex_valid && ex_ready` at a rising edge. All `ex_*` inputs are captured into internal registers.
- **Op class decode:** priority ld > str > alu > cmp > jmp. If no class flag is set, the bundle is a NOP.
- **States:**
  - IDLE:
    - Accept of ld/str → ACCESS.
    - Accept of any other class → IDLE; the writeback for it is registered in the same edge.
  - ACCESS:
    - `mem_req`=1. `mem_addr`, `mem_we` and `mem_wdata` come from the captured registers and stay stable.
    - `mem_ack`=1 → IDLE and register the writeback.
    - Timeout counter == TIMEOUT-1 with no ack → IDLE. Set `mem_err`, then emit the writeback with all write enables 0.
- **Timeout counter:** width $clog2(TIMEOUT). Cleared on entry to ACCESS, increments each ACCESS cycle.
- **Writeback contents, registered on the completing edge:**
  - alu: `wb_reg_we`=1, `wb_rd_val`=result.
  - ld: `wb_reg_we`=1, `wb_rd_val`=`mem_rdata` captured at ack.
  - str: all write enables 0.
  - cmp: `wb_cpsr_we`=1, `wb_cpsr`=`ex_cpsr`.
  - jmp: `wb_pc_we`=`ex_taken`, `wb_pc`=`ex_md`.
  - NOP: all write enables 0.
- **`wb_rd_num`:** always the captured `ex_rd_num`.
- **Write enables:** `wb_reg_we`, `wb_cpsr_we` and `wb_pc_we` are forced 0 whenever `wb_valid`=0.
- **`wb_*` data fields:** hold their last value between pulses.
- **Ignored inputs:** `mem_ack` in IDLE is ignored. `ex_*` inputs while `ex_ready`=0 are ignored; execute must hold them.

## Timing
- **Reset (asynchronous):**
  - All outputs 0 and `ex_ready`=0 while `rst` is high.
  - State IDLE; counter and `mem_err` cleared.
  - `ex_ready`=1 from the first cycle after deassertion.
- **Non-memory op:** accepted at edge T → `wb_valid`=1 during cycle T+1. `ex_ready` stays 1, so throughput is one instruction per cycle.
- **Memory op, with ack:**
  - Accepted at edge T → `mem_req`=1 from cycle T+1.
  - Ack sampled at edge T+1+k (k≥0) → `mem_req`=0, `wb_valid`=1 and `ex_ready`=1 in cycle T+2+k.
  - Minimum load-to-writeback latency is 2 cycles.
- **Memory op, timeout:** `mem_req` is high for exactly TIMEOUT cycles. In the following cycle `wb_valid`=1, `mem_err`=1 and `ex_ready`=1.
- **Reset during ACCESS:** `mem_req` drops asynchronously and the access is abandoned. A late ack after reset is ignored.
- **Ack on the final timeout cycle:** the ack wins; no error.

## Test plan
- Reset released, then alu bundle (result=0x12345678, rd=3) → next cycle `wb_valid`=1, `wb_reg_we`=1, `wb_rd_num`=3, `wb_rd_val`=0x12345678.
- Three back-to-back cycles of cmp (cpsr=0x8), jmp (taken=1, md=0x40), jmp (taken=0) → three consecutive `wb_valid` pulses:
  - 1st: `wb_cpsr_we`=1, `wb_cpsr`=0x8.
  - 2nd: `wb_pc_we`=1, `wb_pc`=0x40.
  - 3rd: `wb_pc_we`=0.
  - `ex_ready` stays 1 throughout.
- ld addr=0x100, rd=5, ack 3 cycles after `mem_req` rises with `mem_rdata`=0xDEADBEEF → `mem_req` high 4 cycles with `mem_we`=0 and `mem_addr`=0x100 stable. `ex_ready` low over the same window. Then `wb_reg_we`=1, `wb_rd_num`=5, `wb_rd_val`=0xDEADBEEF.
- str addr=0x20, data=0xA5A5A5A5, ack same cycle `mem_req` rises → `mem_we`=1, `mem_wdata`=0xA5A5A5A5. Next cycle `wb_valid`=1 with all write enables 0.
- ld with no ack, TIMEOUT=16 → `mem_req` high exactly 16 cycles. Then `mem_err`=1, `wb_valid`=1 with `wb_reg_we`=0, and the next alu op proceeds normally. `mem_err` stays 1 until reset.
- Reset asserted 2 cycles into ACCESS, ack pulsed after release → all outputs 0, state IDLE, the stale ack produces no `wb_valid`.
